// File: rtl/alu_result_writeback.sv
// Pending ALU result queue feeding the register-file write port, with a
// youngest-first forwarding lookup over results that have not yet committed.
module alu_result_writeback #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_result,
    input  logic [ADDR_W-1:0]        in_dest,
    input  logic                     wb_stall,
    output logic                     out_we,
    output logic [ADDR_W-1:0]        out_addr,
    output logic [DATA_W-1:0]        out_data,
    input  logic [ADDR_W-1:0]        fwd_addr,
    output logic                     fwd_hit,
    output logic [DATA_W-1:0]        fwd_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] data_q [DEPTH];
    logic [ADDR_W-1:0] dest_q [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push;
    logic              pop;
    logic [PTR_W-1:0]  idx;

    assign in_ready = (count != CNT_W'(DEPTH));
    // r0 writes complete the handshake but are dropped, since r0 is hardwired zero
    assign push     = in_valid && in_ready && (in_dest != '0);
    assign pop      = (count != '0) && !wb_stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            valid_q  <= '0;
            out_we   <= 1'b0;
            out_addr <= '0;
            out_data <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                dest_q[i] <= '0;
            end
        end else begin
            if (push) begin
                data_q[wr_ptr]  <= in_result;
                dest_q[wr_ptr]  <= in_dest;
                valid_q[wr_ptr] <= 1'b1;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop) begin
                out_addr        <= dest_q[rd_ptr];
                out_data        <= data_q[rd_ptr];
                valid_q[rd_ptr] <= 1'b0;
                rd_ptr          <= rd_ptr + 1'b1;
            end
            out_we <= pop;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Output stage has lowest priority; queue is scanned oldest to newest so the youngest match wins
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = '0;
        if (fwd_addr != '0) begin
            if (out_we && (out_addr == fwd_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = out_data;
            end
            for (int k = 0; k < DEPTH; k++) begin
                idx = rd_ptr + PTR_W'(k);
                if (valid_q[idx] && (dest_q[idx] == fwd_addr)) begin
                    fwd_hit  = 1'b1;
                    fwd_data = data_q[idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_result_writeback.sv
// Directed bench for alu_result_writeback: a queue-based model is compared every
// cycle, and literal expectations pin the key scenarios.
module tb_alu_result_writeback;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 4;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_result;
    logic [ADDR_W-1:0] in_dest;
    logic              wb_stall;
    logic              out_we;
    logic [ADDR_W-1:0] out_addr;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] fwd_addr;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;
    logic [2:0]        count;

    int total = 0;
    int bad   = 0;

    alu_result_writeback #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result), .in_dest(in_dest),
        .wb_stall(wb_stall),
        .out_we(out_we), .out_addr(out_addr), .out_data(out_data),
        .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
        .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a plain FIFO of pending results plus the committed write
    typedef struct packed {
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } ent_t;

    ent_t              m_q[$];
    logic              m_out_we;
    logic [ADDR_W-1:0] m_out_addr;
    logic [DATA_W-1:0] m_out_data;

    always @(posedge clk or posedge reset) begin : model_proc
        int sz;
        bit do_push;
        if (reset) begin
            m_q.delete();
            m_out_we   <= 1'b0;
            m_out_addr <= '0;
            m_out_data <= '0;
        end else begin
            sz      = m_q.size();
            do_push = in_valid && (sz != DEPTH) && (in_dest != '0);
            if (sz != 0 && !wb_stall) begin
                m_out_we   <= 1'b1;
                m_out_addr <= m_q[0].dest;
                m_out_data <= m_q[0].data;
                m_q.pop_front();
            end else begin
                m_out_we <= 1'b0;
            end
            if (do_push) m_q.push_back({in_dest, in_result});
        end
    end

    function automatic void model_fwd(input logic [ADDR_W-1:0] a, output logic hit,
                                      output logic [DATA_W-1:0] d);
        hit = 1'b0;
        d   = '0;
        if (a != '0) begin
            for (int i = m_q.size() - 1; i >= 0; i--) begin
                if (!hit && m_q[i].dest == a) begin
                    hit = 1'b1;
                    d   = m_q[i].data;
                end
            end
            if (!hit && m_out_we && m_out_addr == a) begin
                hit = 1'b1;
                d   = m_out_data;
            end
        end
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    logic [ADDR_W-1:0] commit_addr[$];
    logic [DATA_W-1:0] commit_data[$];

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin : compare_proc
        logic              e_hit;
        logic [DATA_W-1:0] e_data;
        if (!reset) begin
            model_fwd(fwd_addr, e_hit, e_data);
            checkOutput("in_ready", 32'(in_ready), 32'(m_q.size() != DEPTH));
            checkOutput("count",    32'(count),    32'(m_q.size()));
            checkOutput("out_we",   32'(out_we),   32'(m_out_we));
            checkOutput("out_addr", 32'(out_addr), 32'(m_out_addr));
            checkOutput("out_data", out_data,      m_out_data);
            checkOutput("fwd_hit",  32'(fwd_hit),  32'(e_hit));
            checkOutput("fwd_data", fwd_data,      e_data);
            if (out_we) begin
                commit_addr.push_back(out_addr);
                commit_data.push_back(out_data);
            end
        end
    end

    // One clock of stimulus: drive just after the falling edge, return at the next one
    task automatic applyStimulus(input logic v, input logic [ADDR_W-1:0] d,
                                 input logic [DATA_W-1:0] data, input logic stall,
                                 input logic [ADDR_W-1:0] fa);
        #1;
        in_valid  = v;
        in_dest   = d;
        in_result = data;
        wb_stall  = stall;
        fwd_addr  = fa;
        @(negedge clk);
    endtask

    task automatic pushUntilAccepted(input logic [ADDR_W-1:0] d, input logic [DATA_W-1:0] data);
        logic acc;
        acc = 1'b0;
        for (int t = 0; t < 8 && !acc; t++) begin
            #1;
            in_valid  = 1'b1;
            in_dest   = d;
            in_result = data;
            wb_stall  = 1'b0;
            acc       = in_ready;
            @(negedge clk);
        end
        checkOutput("accept_timeout", 32'(acc), 32'd1);
    endtask

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_dest   = '0;
        in_result = '0;
        wb_stall  = 1'b0;
        fwd_addr  = '0;
        @(negedge clk);
        checkOutput("rst_out_we",   32'(out_we),   32'd0);
        checkOutput("rst_out_addr", 32'(out_addr), 32'd0);
        checkOutput("rst_out_data", out_data,      32'd0);
        checkOutput("rst_count",    32'(count),    32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        #1 reset = 1'b0;
        @(negedge clk);

        // Single result latency
        applyStimulus(1'b1, 5'd5, 32'h0000_00AA, 1'b0, 5'd5);
        checkOutput("single_count", 32'(count), 32'd1);
        checkOutput("single_fwd_q", fwd_data, 32'hAA);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd5);
        checkOutput("single_we",   32'(out_we),   32'd1);
        checkOutput("single_addr", 32'(out_addr), 32'd5);
        checkOutput("single_data", out_data,      32'hAA);
        checkOutput("single_fwd_out", 32'(fwd_hit), 32'd1);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd5);
        checkOutput("single_we_drop", 32'(out_we),  32'd0);
        checkOutput("single_fwd_gone", 32'(fwd_hit), 32'd0);

        // r0 writes are accepted and discarded
        checkOutput("r0_ready", 32'(in_ready), 32'd1);
        applyStimulus(1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0);
        checkOutput("r0_count", 32'(count), 32'd0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
            checkOutput("r0_no_we", 32'(out_we), 32'd0);
        end

        // Fill under stall, then drain across the pointer wrap
        commit_addr.delete();
        commit_data.delete();
        for (int i = 1; i <= 4; i++)
            applyStimulus(1'b1, 5'(i), 32'h100 + 32'(i), 1'b1, 5'(i));
        checkOutput("full_count", 32'(count),    32'd4);
        checkOutput("full_ready", 32'(in_ready), 32'd0);
        applyStimulus(1'b1, 5'd5, 32'h105, 1'b1, 5'd3);
        checkOutput("full_hold", 32'(count), 32'd4);
        pushUntilAccepted(5'd5, 32'h105);
        pushUntilAccepted(5'd6, 32'h106);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd6);
        checkOutput("wrap_commits", 32'(commit_addr.size()), 32'd6);
        for (int i = 0; i < 6 && i < commit_addr.size(); i++) begin
            checkOutput("wrap_addr", 32'(commit_addr[i]), 32'(i + 1));
            checkOutput("wrap_data", commit_data[i], 32'h101 + 32'(i));
        end

        // Forwarding picks the youngest duplicate
        applyStimulus(1'b1, 5'd7, 32'h11, 1'b1, 5'd7);
        applyStimulus(1'b1, 5'd7, 32'h22, 1'b1, 5'd7);
        checkOutput("fwd_dup_hit",  32'(fwd_hit), 32'd1);
        checkOutput("fwd_dup_data", fwd_data,     32'h22);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd3);
        checkOutput("fwd_miss_hit",  32'(fwd_hit), 32'd0);
        checkOutput("fwd_miss_data", fwd_data,     32'd0);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd7);
        checkOutput("fwd_mid_data", fwd_data, 32'h22);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd7);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd7);
        checkOutput("fwd_done_hit", 32'(fwd_hit), 32'd0);

        // Push and pop in the same cycle at count=2
        applyStimulus(1'b1, 5'd2, 32'h1, 1'b1, 5'd2);
        applyStimulus(1'b1, 5'd3, 32'h2, 1'b1, 5'd3);
        checkOutput("pp_pre_count", 32'(count), 32'd2);
        applyStimulus(1'b1, 5'd4, 32'h3, 1'b0, 5'd4);
        checkOutput("pp_count", 32'(count),    32'd2);
        checkOutput("pp_we",    32'(out_we),   32'd1);
        checkOutput("pp_addr",  32'(out_addr), 32'd2);
        checkOutput("pp_data",  out_data,      32'h1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd4);

        // Asynchronous reset in the middle of a drain
        applyStimulus(1'b1, 5'd9,  32'h90, 1'b1, 5'd9);
        applyStimulus(1'b1, 5'd10, 32'hA0, 1'b1, 5'd9);
        applyStimulus(1'b1, 5'd11, 32'hB0, 1'b1, 5'd9);
        checkOutput("mid_count", 32'(count), 32'd3);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd9);
        checkOutput("mid_we", 32'(out_we), 32'd1);
        #2 reset = 1'b1;
        #1;
        checkOutput("arst_we",    32'(out_we),  32'd0);
        checkOutput("arst_count", 32'(count),   32'd0);
        checkOutput("arst_fwd",   32'(fwd_hit), 32'd0);
        @(negedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd10);
            checkOutput("arst_no_we", 32'(out_we), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
